// File: rtl/mem_access_unit.sv
`default_nettype none
// ============================================================================
//  Module      : mem_access_unit
//  Description : Load/store unit between the execute stage and a word-wide
//                synchronous data memory (Dmemory32). It handles byte and
//                halfword accesses: loads get lane extraction plus sign or
//                zero extension, and sub-word stores use a read-modify-write
//                sequence. Word stores complete without reading memory.
//  Revision    : 1.0  - initial release
// ----------------------------------------------------------------------------
//  Ports
//    clock_i          system clock, rising edge
//    rst_ni           asynchronous active-low reset
//    req_i            access request, operands held stable until done_o
//    isStore_i        1 = store, 0 = load
//    size_i           00 byte, 01 halfword, 10/11 word
//    isUnsigned_i     1 = zero-extend loads, 0 = sign-extend
//    address_i        byte address
//    storeData_i      store operand (sub-word taken from the LSBs)
//    memAddress_o     word-aligned memory address
//    memWrite_o       memory write enable
//    memWriteData_o   full word written to memory
//    memReadData_i    memory read data, valid the cycle after the address
//    loadData_o       extended load result, held until the next request
//    done_o           one-cycle completion pulse
//    err_o            misalignment flag, valid with done_o
//  Build option
//    MISALIGN_TRAP_EN defined   : misaligned halfword/word accesses trap
//                                 (IDLE -> DONE, err_o = 1, no side effects)
//    MISALIGN_TRAP_EN undefined : low address bits are ignored, err_o = 0
// ============================================================================
module mem_access_unit (
  input  logic        clock_i,
  input  logic        rst_ni,
  input  logic        req_i,
  input  logic        isStore_i,
  input  logic [1:0]  size_i,
  input  logic        isUnsigned_i,
  input  logic [31:0] address_i,
  input  logic [31:0] storeData_i,
  output logic [31:0] memAddress_o,
  output logic        memWrite_o,
  output logic [31:0] memWriteData_o,
  input  logic [31:0] memReadData_i,
  output logic [31:0] loadData_o,
  output logic        done_o,
  output logic        err_o
);

  localparam logic [1:0] c_idle = 2'd0;
  localparam logic [1:0] c_rd   = 2'd1;
  localparam logic [1:0] c_wr   = 2'd2;
  localparam logic [1:0] c_done = 2'd3;

  logic [1:0]  state_q, state_d;
  logic [31:0] loadData_q, loadData_d;
  logic [31:0] merge_q, merge_d;

  logic        w_is_word;
  logic        w_misalign;
  logic [7:0]  w_byte;
  logic [15:0] w_half;
  logic [31:0] w_load_ext;
  logic [31:0] w_merged;

  // Reserved size 11 behaves as a word.
  assign w_is_word    = size_i[1];
  assign memAddress_o = {address_i[31:2], 2'b00};
  assign loadData_o   = loadData_q;

`ifdef MISALIGN_TRAP_EN
  logic w_is_half;
  logic err_q, err_d;

  assign w_is_half  = (size_i == 2'b01);
  assign w_misalign = (w_is_half && address_i[0]) ||
                      (w_is_word && (address_i[1:0] != 2'b00));

  // The flag is decided when a request is accepted and held until the next.
  always_comb begin
    err_d = err_q;
    if (state_q == c_idle && req_i) err_d = w_misalign;
  end

  always_ff @(posedge clock_i or negedge rst_ni) begin
    if (!rst_ni) err_q <= 1'b0;
    else         err_q <= err_d;
  end

  assign err_o = err_q;
`else
  assign w_misalign = 1'b0;
  assign err_o      = 1'b0;
`endif

  // ---------------------------------------------------------------- FSM: state
  always_ff @(posedge clock_i or negedge rst_ni) begin
    if (!rst_ni) state_q <= c_idle;
    else         state_q <= state_d;
  end

  // ---------------------------------------------------------- FSM: next state
  always_comb begin
    state_d = state_q;
    case (state_q)
      c_idle: begin
        if (req_i) begin
          // Word stores need no read; trapped accesses skip memory entirely.
          if (w_misalign || (isStore_i && w_is_word)) state_d = c_done;
          else                                        state_d = c_rd;
        end
      end
      c_rd:    state_d = isStore_i ? c_wr : c_done;
      c_wr:    state_d = c_done;
      c_done:  state_d = c_idle;
      default: state_d = c_idle;
    endcase
  end

  // -------------------------------------------------------------- FSM: outputs
  always_comb begin
    memWrite_o     = 1'b0;
    memWriteData_o = storeData_i;
    done_o         = 1'b0;
    case (state_q)
      c_idle:  memWrite_o = req_i && isStore_i && w_is_word && !w_misalign;
      c_wr: begin
        memWrite_o     = 1'b1;
        memWriteData_o = merge_q;
      end
      c_done:  done_o = 1'b1;
      default: ;
    endcase
    // The IDLE write term is combinational on req_i, so the enable is also
    // gated directly by reset to keep memory untouched while reset is low.
    if (!rst_ni) memWrite_o = 1'b0;
  end

  // ------------------------------------------------------ lane select / merge
  always_comb begin
    case (address_i[1:0])
      2'd0:    w_byte = memReadData_i[7:0];
      2'd1:    w_byte = memReadData_i[15:8];
      2'd2:    w_byte = memReadData_i[23:16];
      default: w_byte = memReadData_i[31:24];
    endcase
    w_half = address_i[1] ? memReadData_i[31:16] : memReadData_i[15:0];

    case (size_i)
      2'b00:   w_load_ext = isUnsigned_i ? {24'h0, w_byte} : {{24{w_byte[7]}}, w_byte};
      2'b01:   w_load_ext = isUnsigned_i ? {16'h0, w_half} : {{16{w_half[15]}}, w_half};
      default: w_load_ext = memReadData_i;
    endcase

    // Only sub-word stores reach the merge; word stores bypass RD.
    w_merged = memReadData_i;
    if (size_i == 2'b00) begin
      case (address_i[1:0])
        2'd0:    w_merged[7:0]   = storeData_i[7:0];
        2'd1:    w_merged[15:8]  = storeData_i[7:0];
        2'd2:    w_merged[23:16] = storeData_i[7:0];
        default: w_merged[31:24] = storeData_i[7:0];
      endcase
    end else if (address_i[1]) begin
      w_merged[31:16] = storeData_i[15:0];
    end else begin
      w_merged[15:0]  = storeData_i[15:0];
    end
  end

  // --------------------------------------------------------- data registers
  always_comb begin
    loadData_d = loadData_q;
    merge_d    = merge_q;
    if (state_q == c_rd) begin
      if (isStore_i) merge_d    = w_merged;
      else           loadData_d = w_load_ext;
    end
  end

  always_ff @(posedge clock_i or negedge rst_ni) begin
    if (!rst_ni) begin
      loadData_q <= 32'h0;
      merge_q    <= 32'h0;
    end else begin
      loadData_q <= loadData_d;
      merge_q    <= merge_d;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_mem_access_unit.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mem_access_unit
//  Description : Self-checking bench for mem_access_unit. A bench-owned
//                synchronous word memory plays Dmemory32; a reference model
//                built from byte-lane arithmetic predicts results, latency
//                and write traffic for directed and random accesses.
//  Revision    : 1.0  - initial release
// ============================================================================
module tb_mem_access_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req, isStore, isUnsigned;
  logic [1:0]  size;
  logic [31:0] address, storeData;
  logic [31:0] memAddress, memWriteData, memReadData, loadData;
  logic        memWrite, done, err;

  logic [31:0] dmem    [0:63];
  logic [31:0] ref_mem [0:63];
  logic [31:0] ref_ld;
  logic        poke_en = 1'b0;
  logic [5:0]  poke_idx = 6'd0;
  logic [31:0] poke_val = 32'h0;

  int n_chk = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  mem_access_unit dut (
    .clock_i        (clk),
    .rst_ni         (rst_n),
    .req_i          (req),
    .isStore_i      (isStore),
    .size_i         (size),
    .isUnsigned_i   (isUnsigned),
    .address_i      (address),
    .storeData_i    (storeData),
    .memAddress_o   (memAddress),
    .memWrite_o     (memWrite),
    .memWriteData_o (memWriteData),
    .memReadData_i  (memReadData),
    .loadData_o     (loadData),
    .done_o         (done),
    .err_o          (err)
  );

  // Synchronous-read data memory; the bench preloads it through the poke port.
  always @(posedge clk) begin
    memReadData <= dmem[memAddress[7:2]];
    if (poke_en)       dmem[poke_idx] <= poke_val;
    else if (memWrite) dmem[memAddress[7:2]] <= memWriteData;
  end

  // ------------------------------------------------------- reference model
  function automatic int nbytes(input logic [1:0] sz);
    return (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
  endfunction

  function automatic int lane_off(input logic [1:0] sz, input logic [31:0] a);
    if (nbytes(sz) == 4) return 0;
    if (nbytes(sz) == 2) return a[1] ? 2 : 0;
    return int'(a[1:0]);
  endfunction

  function automatic logic [31:0] model_load(input logic [31:0] word, input logic [1:0] sz,
                                             input logic uns, input logic [31:0] a);
    int nb = nbytes(sz);
    logic [63:0] mask = (64'd1 << (8 * nb)) - 64'd1;
    logic [63:0] v = ({32'd0, word} >> (8 * lane_off(sz, a))) & mask;
    if (!uns && nb < 4 && v[8 * nb - 1]) v = v | ~mask;
    return v[31:0];
  endfunction

  function automatic logic [31:0] model_store(input logic [31:0] old, input logic [1:0] sz,
                                              input logic [31:0] a, input logic [31:0] d);
    int sh = 8 * lane_off(sz, a);
    logic [63:0] mask = ((64'd1 << (8 * nbytes(sz))) - 64'd1) << sh;
    logic [63:0] v = ({32'd0, old} & ~mask) | (({32'd0, d} << sh) & mask);
    return v[31:0];
  endfunction

  function automatic logic model_trap(input logic [1:0] sz, input logic [31:0] a);
`ifdef MISALIGN_TRAP_EN
    return (sz == 2'd1 && a[0]) || (sz[1] && a[1:0] != 2'd0);
`else
    return 1'b0;
`endif
  endfunction

  // ------------------------------------------------------------ drivers
  task automatic poke(input logic [31:0] a, input logic [31:0] v);
    @(posedge clk); #1;
    poke_en = 1'b1; poke_idx = a[7:2]; poke_val = v;
    ref_mem[a[7:2]] = v;
    @(posedge clk); #1;
    poke_en = 1'b0;
  endtask

  // Issues one access; req cycle is cycle 1. Reports the done cycle (0 on
  // timeout), write count, last write data, err/loadData at done, and whether
  // done or a write shows up in the cycle after done.
  task automatic do_access(input logic st, input logic [1:0] sz, input logic uns,
                           input logic [31:0] a, input logic [31:0] d,
                           output int lat, output int nwr, output logic [31:0] wdat,
                           output logic errv, output logic [31:0] ld, output logic after);
    lat = 0; nwr = 0; wdat = '0; errv = 1'b0; ld = '0; after = 1'b0;
    @(posedge clk); #1;
    req = 1'b1; isStore = st; size = sz; isUnsigned = uns; address = a; storeData = d;
    for (int c = 1; c <= 8; c++) begin
      @(negedge clk);
      if (memWrite) begin nwr++; wdat = memWriteData; end
      if (done) begin lat = c; errv = err; ld = loadData; break; end
      @(posedge clk); #1;
    end
    @(posedge clk); #1;
    req = 1'b0;
    @(negedge clk);
    after = done | memWrite;
  endtask

  // ------------------------------------------------------------ tests
  task automatic test_reset();
    rst_n = 1'b0;
    req = 1'b1; isStore = 1'b1; size = 2'd2; isUnsigned = 1'b0;
    address = 32'h0000_0013; storeData = 32'hCAFE_F00D;
    for (int i = 0; i < 64; i++) poke({24'd0, 6'(i), 2'b00}, $urandom);
    #1;
    n_chk++; if (memWrite !== 1'b0) begin n_err++; $display("FAIL reset_memWrite: got %b want 0", memWrite); end
    n_chk++; if (done !== 1'b0) begin n_err++; $display("FAIL reset_done: got %b want 0", done); end
    n_chk++; if (err !== 1'b0) begin n_err++; $display("FAIL reset_err: got %b want 0", err); end
    n_chk++; if (loadData !== 32'h0) begin n_err++; $display("FAIL reset_loadData: got %h want 0", loadData); end
    n_chk++; if (memAddress !== 32'h10) begin n_err++; $display("FAIL reset_memAddress: got %h want 00000010", memAddress); end
    req = 1'b0;
    @(negedge clk); rst_n = 1'b1;
    ref_ld = 32'h0;
  endtask

  task automatic test_word_store();
    int lat, nwr; logic [31:0] wd, ld; logic e, aft;
    do_access(1'b1, 2'd2, 1'b0, 32'h10, 32'hDEADBEEF, lat, nwr, wd, e, ld, aft);
    ref_mem[4] = 32'hDEADBEEF;
    n_chk++; if (lat !== 2) begin n_err++; $display("FAIL sw_latency: got %0d want 2", lat); end
    n_chk++; if (nwr !== 1 || wd !== 32'hDEADBEEF) begin n_err++; $display("FAIL sw_write: got %0d writes data %h want 1 DEADBEEF", nwr, wd); end
    n_chk++; if (aft !== 1'b0) begin n_err++; $display("FAIL sw_after_done: got %b want 0", aft); end
    do_access(1'b0, 2'd2, 1'b0, 32'h10, 32'h0, lat, nwr, wd, e, ld, aft);
    ref_ld = 32'hDEADBEEF;
    n_chk++; if (lat !== 3) begin n_err++; $display("FAIL lw_latency: got %0d want 3", lat); end
    n_chk++; if (ld !== 32'hDEADBEEF || nwr !== 0) begin n_err++; $display("FAIL lw_data: got %h writes %0d want DEADBEEF 0", ld, nwr); end
  endtask

  task automatic test_sub_store();
    int lat, nwr; logic [31:0] wd, ld; logic e, aft;
    poke(32'h20, 32'h11223344);
    do_access(1'b1, 2'd0, 1'b0, 32'h21, 32'h000000AA, lat, nwr, wd, e, ld, aft);
    ref_mem[8] = 32'h1122AA44;
    n_chk++; if (lat !== 4) begin n_err++; $display("FAIL sb_latency: got %0d want 4", lat); end
    n_chk++; if (nwr !== 1 || wd !== 32'h1122AA44) begin n_err++; $display("FAIL sb_write: got %0d writes data %h want 1 1122AA44", nwr, wd); end
    poke(32'h40, 32'hAAAAAAAA);
    do_access(1'b1, 2'd1, 1'b0, 32'h42, 32'h5A5A1234, lat, nwr, wd, e, ld, aft);
    ref_mem[16] = 32'h1234AAAA;
    n_chk++; if (lat !== 4) begin n_err++; $display("FAIL sh_latency: got %0d want 4", lat); end
    n_chk++; if (nwr !== 1 || wd !== 32'h1234AAAA) begin n_err++; $display("FAIL sh_write: got %0d writes data %h want 1 1234AAAA", nwr, wd); end
    n_chk++; if (dmem[16] !== 32'h1234AAAA) begin n_err++; $display("FAIL sh_mem: got %h want 1234AAAA", dmem[16]); end
  endtask

  task automatic test_loads();
    int lat, nwr; logic [31:0] wd, ld; logic e, aft;
    logic [31:0] addrs [4] = '{32'h30, 32'h31, 32'h31, 32'h32};
    logic [1:0]  sizes [4] = '{2'd0, 2'd0, 2'd0, 2'd1};
    logic        unss  [4] = '{1'b0, 1'b0, 1'b1, 1'b0};
    logic [31:0] exps  [4] = '{32'h0000007F, 32'hFFFFFFFF, 32'h000000FF, 32'hFFFF8000};
    poke(32'h30, 32'h8000FF7F);
    for (int i = 0; i < 4; i++) begin
      do_access(1'b0, sizes[i], unss[i], addrs[i], 32'h0, lat, nwr, wd, e, ld, aft);
      ref_ld = exps[i];
      n_chk++; if (ld !== exps[i] || lat !== 3) begin n_err++; $display("FAIL load_%0d: got %h lat %0d want %h lat 3", i, ld, lat, exps[i]); end
    end
  endtask

  task automatic test_reset_mid_op();
    poke(32'h50, 32'h55667788);
    @(posedge clk); #1;
    req = 1'b1; isStore = 1'b1; size = 2'd0; isUnsigned = 1'b0; address = 32'h52; storeData = 32'h11;
    @(posedge clk); @(posedge clk);
    @(negedge clk);
    n_chk++; if (memWrite !== 1'b1) begin n_err++; $display("FAIL midrst_wr_reached: got %b want 1", memWrite); end
    rst_n = 1'b0; #1;
    n_chk++; if (memWrite !== 1'b0) begin n_err++; $display("FAIL midrst_memWrite: got %b want 0", memWrite); end
    req = 1'b0;
    @(posedge clk); @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    ref_ld = 32'h0;
    n_chk++; if (dmem[20] !== 32'h55667788) begin n_err++; $display("FAIL midrst_mem: got %h want 55667788", dmem[20]); end
    n_chk++; if (done !== 1'b0 || loadData !== 32'h0) begin n_err++; $display("FAIL midrst_state: got done %b ld %h want 0 0", done, loadData); end
  endtask

  task automatic test_misalign();
    int lat, nwr; logic [31:0] wd, ld; logic e, aft;
    poke(32'h10, 32'h0BADF00D);
    do_access(1'b0, 2'd2, 1'b0, 32'h13, 32'h0, lat, nwr, wd, e, ld, aft);
`ifdef MISALIGN_TRAP_EN
    n_chk++; if (lat !== 2 || e !== 1'b1) begin n_err++; $display("FAIL misalign_trap: got lat %0d err %b want 2 1", lat, e); end
    n_chk++; if (ld !== ref_ld) begin n_err++; $display("FAIL misalign_ld: got %h want %h", ld, ref_ld); end
`else
    ref_ld = 32'h0BADF00D;
    n_chk++; if (lat !== 3 || e !== 1'b0) begin n_err++; $display("FAIL misalign_lat: got lat %0d err %b want 3 0", lat, e); end
    n_chk++; if (ld !== 32'h0BADF00D) begin n_err++; $display("FAIL misalign_ld: got %h want 0BADF00D", ld); end
`endif
  endtask

  task automatic test_back_to_back();
    int lat, nwr; logic [31:0] wd, ld; logic e, aft;
    logic [31:0] a = {24'd0, 8'($urandom_range(0, 255))};
    do_access(1'b0, 2'd0, 1'b1, a, 32'h0, lat, nwr, wd, e, ld, aft);
    ref_ld = model_load(ref_mem[a[7:2]], 2'd0, 1'b1, a);
    n_chk++; if (aft !== 1'b0) begin n_err++; $display("FAIL b2b_single_done: got %b want 0", aft); end
    repeat (3) @(negedge clk);
    n_chk++; if (loadData !== ref_ld || memWrite !== 1'b0) begin n_err++; $display("FAIL idle_hold: got %h we %b want %h 0", loadData, memWrite, ref_ld); end
  endtask

  task automatic test_random(input int n);
    int lat, nwr, elat, ewr; logic [31:0] wd, ld, d, a, ewd; logic e, aft, st, uns, trap;
    logic [1:0] sz;
    for (int i = 0; i < n; i++) begin
      st = 1'($urandom); uns = 1'($urandom); sz = 2'($urandom);
      a = {24'd0, 8'($urandom_range(0, 255))}; d = $urandom;
      trap = model_trap(sz, a); ewd = 32'h0;
      if (trap)          begin elat = 2; ewr = 0; end
      else if (!st)      begin elat = 3; ewr = 0; ref_ld = model_load(ref_mem[a[7:2]], sz, uns, a); end
      else if (sz[1])    begin elat = 2; ewr = 1; ewd = d; end
      else               begin elat = 4; ewr = 1; ewd = model_store(ref_mem[a[7:2]], sz, a, d); end
      if (ewr == 1) ref_mem[a[7:2]] = ewd;
      do_access(st, sz, uns, a, d, lat, nwr, wd, e, ld, aft);
      n_chk++; if (lat !== elat) begin n_err++; $display("FAIL rnd%0d_latency: got %0d want %0d", i, lat, elat); end
      n_chk++; if (nwr !== ewr || (ewr == 1 && wd !== ewd)) begin n_err++; $display("FAIL rnd%0d_write: got %0d/%h want %0d/%h", i, nwr, wd, ewr, ewd); end
      n_chk++; if (ld !== ref_ld) begin n_err++; $display("FAIL rnd%0d_loadData: got %h want %h", i, ld, ref_ld); end
      n_chk++; if (e !== trap || aft !== 1'b0) begin n_err++; $display("FAIL rnd%0d_err: got err %b after %b want %b 0", i, e, aft, trap); end
    end
    for (int j = 0; j < 64; j++) begin
      n_chk++; if (dmem[j] !== ref_mem[j]) begin n_err++; $display("FAIL mem_word%0d: got %h want %h", j, dmem[j], ref_mem[j]); end
    end
  endtask

  initial begin
    test_reset();
    test_word_store();
    test_sub_store();
    test_loads();
    test_reset_mid_op();
    test_misalign();
    test_back_to_back();
    test_random(80);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
`default_nettype wire
